// File: rtl/tof_i2c_sequencer.sv
// Register-access sequencer in front of the ToF I2C byte engine: stages write bytes,
// steps the engine one byte per ready edge, collects read bytes in an RX FIFO.
module tof_i2c_sequencer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_is_read,
    input  logic [6:0]             req_slave_addr,
    input  logic [15:0]            req_reg_addr,
    input  logic [$clog2(DEPTH):0] req_len,
    input  logic [7:0]             wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   i2c_start,
    output logic                   i2c_reset,
    output logic                   i2c_is_read,
    output logic [6:0]             i2c_slave_addr,
    output logic [15:0]            i2c_reg_addr,
    output logic [16:0]            i2c_nb_of_bytes,
    output logic [7:0]             i2c_data_in,
    input  logic [7:0]             i2c_data_out,
    input  logic                   i2c_ready
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = PTR_W + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_XFER, S_FINISH, S_ABORT} state_t;

    state_t             state_q;
    logic               rd_q;
    logic [6:0]         slave_q;
    logic [15:0]        reg_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx_q;
    logic [WD_W-1:0]    wd_q;
    logic               abort_q;
    logic               ready_prev_q;
    logic               req_ready_q;
    logic               wr_ready_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic               start_q;
    logic               i2c_reset_q;
    logic [16:0]        nb_q;
    logic [7:0]         data_in_q;
    logic [7:0]         tx_mem [DEPTH];

    logic [7:0]         rx_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               rd_valid_q;
    logic [7:0]         rd_data_q;

    logic               rise_c;
    logic               edge_c;
    logic               len_ok_c;
    logic               fits_c;
    logic               accept_c;
    logic               tx_we_c;
    logic               push_c;
    logic               pop_c;
    logic               wd_expired_c;
    logic               ready_if_idle_c;
    logic [LEN_W-1:0]   k_next_c;
    logic [LEN_W-1:0]   cnt_after_pop_c;
    logic [LEN_W-1:0]   cnt_d;
    logic [LEN_W-1:0]   free_q_c;
    logic [LEN_W-1:0]   free_d_c;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [7:0]         head_c;

    // Handshake, admission and byte-boundary decode
    always_comb begin
        rise_c          = i2c_ready & ~ready_prev_q;
        edge_c          = i2c_ready ^ ready_prev_q;
        len_ok_c        = (req_len != '0) && (req_len <= LEN_W'(DEPTH));
        free_q_c        = LEN_W'(DEPTH) - cnt_q;
        fits_c          = !req_is_read || !len_ok_c || (req_len <= free_q_c);
        accept_c        = (state_q == S_IDLE) && req_valid && req_ready_q && fits_c;
        tx_we_c         = (state_q == S_LOAD) && wr_valid && wr_ready_q;
        push_c          = (state_q == S_XFER) && rd_q && rise_c;
        pop_c           = rd_ready && rd_valid_q;
        wd_expired_c    = (wd_q == WD_W'(TIMEOUT - 1));
        k_next_c        = idx_q + LEN_W'(1);
        cnt_after_pop_c = cnt_q - LEN_W'(pop_c);
        cnt_d           = cnt_after_pop_c + LEN_W'(push_c);
        free_d_c        = LEN_W'(DEPTH) - cnt_d;
        rd_ptr_d        = rd_ptr_q + PTR_W'(pop_c);
        head_c          = (cnt_after_pop_c == '0) ? i2c_data_out : rx_mem[rd_ptr_d];
        ready_if_idle_c = !(req_valid && req_is_read && len_ok_c && (req_len > free_d_c));
    end

    // Transaction FSM with registered engine and handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rd_q         <= 1'b0;
            slave_q      <= '0;
            reg_q        <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            wd_q         <= '0;
            abort_q      <= 1'b0;
            ready_prev_q <= 1'b0;
            req_ready_q  <= 1'b0;
            wr_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            start_q      <= 1'b0;
            i2c_reset_q  <= 1'b0;
            nb_q         <= '0;
            data_in_q    <= '0;
        end else begin
            ready_prev_q <= i2c_ready;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            start_q      <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    req_ready_q <= ready_if_idle_c;
                    if (accept_c) begin
                        if (!len_ok_c) begin
                            error_q <= 1'b1;
                        end else begin
                            rd_q        <= req_is_read;
                            slave_q     <= req_slave_addr;
                            reg_q       <= req_reg_addr;
                            len_q       <= req_len;
                            idx_q       <= '0;
                            busy_q      <= 1'b1;
                            req_ready_q <= 1'b0;
                            if (req_is_read) begin
                                state_q   <= S_START;
                                start_q   <= 1'b1;
                                nb_q      <= 17'(req_len - LEN_W'(1));
                                data_in_q <= '0;
                            end else begin
                                state_q    <= S_LOAD;
                                wr_ready_q <= 1'b1;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (tx_we_c) begin
                        idx_q <= k_next_c;
                        if (k_next_c == len_q) begin
                            wr_ready_q <= 1'b0;
                            state_q    <= S_START;
                            start_q    <= 1'b1;
                            nb_q       <= 17'(len_q - LEN_W'(1));
                            // byte 0 is still on the bus when the length is 1
                            data_in_q  <= (idx_q == '0) ? wr_data : tx_mem[0];
                        end
                    end
                end
                S_START: begin
                    state_q <= S_XFER;
                    idx_q   <= '0;
                    wd_q    <= '0;
                end
                S_XFER: begin
                    if (edge_c) begin
                        wd_q <= '0;
                        if (rise_c) begin
                            idx_q <= k_next_c;
                            if (k_next_c == len_q) begin
                                state_q <= S_FINISH;
                            end else begin
                                nb_q <= (nb_q == '0) ? '0 : nb_q - 17'd1;
                                if (!rd_q) data_in_q <= tx_mem[k_next_c[PTR_W-1:0]];
                            end
                        end
                    end else if (wd_expired_c) begin
                        state_q     <= S_ABORT;
                        i2c_reset_q <= 1'b1;
                        abort_q     <= 1'b0;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_FINISH: begin
                    if (!i2c_ready) begin
                        state_q     <= S_IDLE;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        req_ready_q <= ready_if_idle_c;
                    end else if (wd_expired_c) begin
                        state_q     <= S_ABORT;
                        i2c_reset_q <= 1'b1;
                        abort_q     <= 1'b0;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_ABORT: begin
                    if (!abort_q) begin
                        abort_q <= 1'b1;
                    end else begin
                        abort_q     <= 1'b0;
                        i2c_reset_q <= 1'b0;
                        error_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                        req_ready_q <= ready_if_idle_c;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (tx_we_c) tx_mem[idx_q[PTR_W-1:0]] <= wr_data;
    end

    // RX FIFO with a registered first-word-fall-through head
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= (cnt_d != '0);
            if (cnt_d != '0) rd_data_q <= head_c;
        end
    end

    always_ff @(posedge clock) begin
        if (push_c) rx_mem[wr_ptr_q] <= i2c_data_out;
    end

    assign req_ready       = req_ready_q;
    assign wr_ready        = wr_ready_q;
    assign rd_data         = rd_data_q;
    assign rd_valid        = rd_valid_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign i2c_start       = start_q;
    assign i2c_reset       = i2c_reset_q;
    assign i2c_is_read     = rd_q;
    assign i2c_slave_addr  = slave_q;
    assign i2c_reg_addr    = reg_q;
    assign i2c_nb_of_bytes = nb_q;
    assign i2c_data_in     = data_in_q;

endmodule
